if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 14 +
 rtl/if_stage.sv | 102 ++++++++++
 tb/tb_if_stage.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage: reset vector, FSM encoding
// and bit positions of the fetch-exception vector.
package if_stage_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_RUN        = 2'd1;
  localparam logic [1:0] ST_WAIT_FLUSH = 2'd2;

  localparam int IF_MISALIGN = 0;
  localparam int IF_ACCFAULT = 1;

endpackage

// File: rtl/if_stage.sv
// Fetch stage: registered pc/next-pc select, one-cycle SRAM read latency; stall[0] freezes
// the pc and parks any taken branch until release; a fetch fault parks the stage until flush.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [63:0] MEM_BASE = 64'h8000_0000,
  parameter logic [63:0] MEM_SIZE = 64'h0800_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [63:0] new_pc,
  input  logic        br_e,
  input  logic [63:0] br_addr,
  output logic        inst_sram_en,
  output logic [63:0] inst_sram_addr,
  output logic        pc_valid,
  output logic [63:0] pc,
  output logic [31:0] csr_vec_h
);

  logic [63:0] pc_reg;
  logic        valid_reg;
  logic [1:0]  state;
  logic        pend_v;
  logic [63:0] pend_addr;

  logic        misalign;
  logic        acc_fault;
  logic        fetch_exc;
  logic        unused_stall;

  assign unused_stall = ^stall[5:1];

  // Window test written as offset compare so MEM_BASE+MEM_SIZE can never wrap.
  assign misalign  = valid_reg && (pc_reg[1:0] != 2'b00);
  assign acc_fault = valid_reg &&
                     !((pc_reg >= MEM_BASE) && ((pc_reg - MEM_BASE) < MEM_SIZE));
  assign fetch_exc = misalign || acc_fault;

  always_comb begin
    csr_vec_h              = '0;
    csr_vec_h[IF_MISALIGN] = misalign;
    csr_vec_h[IF_ACCFAULT] = acc_fault;
  end

  assign pc             = pc_reg;
  assign pc_valid       = valid_reg;
  assign inst_sram_en   = valid_reg;
  assign inst_sram_addr = {pc_reg[63:3], 3'b000};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg    <= RESET_PC;
      valid_reg <= 1'b0;
      state     <= ST_IDLE;
      pend_v    <= 1'b0;
      pend_addr <= '0;
    end else if (flush) begin
      pc_reg    <= new_pc;
      valid_reg <= 1'b1;
      state     <= ST_RUN;
      pend_v    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          valid_reg <= 1'b1;
          state     <= ST_RUN;
        end
        ST_RUN: begin
          if (!stall[0]) begin
            pend_v <= 1'b0;
            if (pend_v) begin
              pc_reg <= pend_addr;
            end else if (br_e) begin
              pc_reg <= br_addr;
            end else if (fetch_exc) begin
              valid_reg <= 1'b0;
              state     <= ST_WAIT_FLUSH;
            end else begin
              pc_reg <= pc_reg + 64'd4;
            end
          end else if (br_e) begin
            // Latest branch seen during a stall is the one that survives.
            pend_v    <= 1'b1;
            pend_addr <= br_addr;
          end
        end
        ST_WAIT_FLUSH: begin
          valid_reg <= 1'b0;
        end
        default: begin
          valid_reg <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed and randomized bench for if_stage against a behavioural fetch model.
module tb_if_stage;

  localparam logic [63:0] RST_PC   = 64'h0000_0000_8000_0000;
  localparam logic [63:0] WIN_BASE = 64'h8000_0000;
  localparam logic [63:0] WIN_SIZE = 64'h0800_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  stall;
  logic        flush;
  logic [63:0] new_pc;
  logic        br_e;
  logic [63:0] br_addr;
  logic        inst_sram_en;
  logic [63:0] inst_sram_addr;
  logic        pc_valid;
  logic [63:0] pc;
  logic [31:0] csr_vec_h;

  int errors = 0;
  int checks = 0;

  // Behavioural model: a fetch pointer, whether it is live, whether we are in
  // the one-cycle warm-up after reset, whether we are parked on a fault, and a
  // list of branch targets collected while stalled (last one wins).
  logic [63:0] m_pc;
  logic        m_live;
  logic        m_warmup;
  logic        m_parked;
  logic [63:0] m_pend[$];

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .new_pc         (new_pc),
    .br_e           (br_e),
    .br_addr        (br_addr),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_addr (inst_sram_addr),
    .pc_valid       (pc_valid),
    .pc             (pc),
    .csr_vec_h      (csr_vec_h)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_exc();
    logic [31:0] v;
    v = 32'd0;
    if (m_live) begin
      if (m_pc % 4 != 0) v = v + 32'd1;
      if (m_pc < WIN_BASE || m_pc >= WIN_BASE + WIN_SIZE) v = v + 32'd2;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic exc;
    exc = (model_exc() != 32'd0);
    if (!rst_n) begin
      m_pc = RST_PC; m_live = 1'b0; m_warmup = 1'b1; m_parked = 1'b0; m_pend.delete();
    end else if (flush) begin
      m_pc = new_pc; m_live = 1'b1; m_warmup = 1'b0; m_parked = 1'b0; m_pend.delete();
    end else if (m_warmup) begin
      m_warmup = 1'b0; m_live = 1'b1;
    end else if (m_parked) begin
      m_live = 1'b0;
    end else if (stall[0]) begin
      if (br_e) m_pend.push_back(br_addr);
    end else begin
      if (m_pend.size() != 0) m_pc = m_pend[$];
      else if (br_e) m_pc = br_addr;
      else if (exc) begin m_parked = 1'b1; m_live = 1'b0; end
      else m_pc = m_pc + 64'd4;
      m_pend.delete();
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("pc_valid", 64'(pc_valid), 64'(m_live));
    chk("inst_sram_en", 64'(inst_sram_en), 64'(m_live));
    chk("inst_sram_addr", inst_sram_addr, m_pc - (m_pc % 8));
    chk("csr_vec_h", 64'(csr_vec_h), 64'(model_exc()));
  endtask

  function automatic logic [63:0] rnd_addr();
    logic [63:0] a;
    int k;
    k = $urandom_range(0, 9);
    a = WIN_BASE + 64'($urandom_range(0, 1023)) * 64'd4;
    if (k == 0) a = a + 64'd2;
    if (k == 1) a = 64'h1000;
    if (k == 2) a = WIN_BASE + WIN_SIZE - 64'd8;
    return a;
  endfunction

  initial begin
    rst_n = 1'b0; stall = 6'd0; flush = 1'b0; new_pc = '0; br_e = 1'b0; br_addr = '0;
    m_pc = RST_PC; m_live = 1'b0; m_warmup = 1'b1; m_parked = 1'b0;

    // Reset, then the warm-up cycle and sequential fetch.
    tick(); tick();
    rst_n = 1'b1;
    chk("reset_valid", 64'(pc_valid), 64'd0);
    chk("reset_pc", pc, 64'h8000_0000);
    tick(); chk("seq0_pc", pc, 64'h8000_0000); chk("seq0_addr", inst_sram_addr, 64'h8000_0000);
    tick(); chk("seq1_pc", pc, 64'h8000_0004); chk("seq1_addr", inst_sram_addr, 64'h8000_0000);
    tick(); chk("seq2_pc", pc, 64'h8000_0008); chk("seq2_addr", inst_sram_addr, 64'h8000_0008);
    tick(); tick();
    chk("pre_branch_pc", pc, 64'h8000_0010);

    // Taken branch.
    br_e = 1'b1; br_addr = 64'h8000_0100;
    tick(); chk("branch_pc", pc, 64'h8000_0100); chk("branch_valid", 64'(pc_valid), 64'd1);
    br_e = 1'b0;

    // Branch arriving mid-stall is held and applied on release.
    stall = 6'h01;
    tick();
    br_e = 1'b1; br_addr = 64'h8000_0200;
    tick();
    br_e = 1'b0;
    tick(); chk("stall_hold_pc", pc, 64'h8000_0100);
    stall = 6'h00;
    tick(); chk("pend_release_pc", pc, 64'h8000_0200);

    // Misaligned target: one cycle of exception, then parked until flush.
    br_e = 1'b1; br_addr = 64'h8000_0102;
    tick(); chk("misalign_vec", 64'(csr_vec_h), 64'h1);
    br_e = 1'b0;
    tick(); chk("parked_valid", 64'(pc_valid), 64'd0);
    br_e = 1'b1; br_addr = 64'h8000_0400;
    tick(); tick();
    br_e = 1'b0;
    chk("parked_ignores_br", 64'(pc_valid), 64'd0);
    flush = 1'b1; new_pc = 64'h8000_1000;
    tick(); chk("flush_pc", pc, 64'h8000_1000); chk("flush_vec", 64'(csr_vec_h), 64'h0);

    // Flush beats a simultaneous branch and stall; no stale redirect afterwards.
    new_pc = 64'h8000_2000; br_e = 1'b1; br_addr = 64'h8000_0300; stall = 6'h01;
    tick(); chk("flush_prio_pc", pc, 64'h8000_2000);
    flush = 1'b0; br_e = 1'b0; stall = 6'h00;
    tick(); chk("flush_clears_pend", pc, 64'h8000_2004);

    // Walking off the end of the window.
    flush = 1'b1; new_pc = 64'h87FF_FFFC;
    tick(); chk("edge_vec_ok", 64'(csr_vec_h), 64'h0);
    flush = 1'b0;
    tick(); chk("edge_pc", pc, 64'h8800_0000); chk("accfault_vec", 64'(csr_vec_h), 64'h2);
    tick(); chk("edge_parked", 64'(pc_valid), 64'd0);
    rst_n = 1'b0;
    tick(); chk("reset_in_wait_pc", pc, 64'h8000_0000); chk("reset_in_wait_valid", 64'(pc_valid), 64'd0);

    // Reset mid-run drops a parked branch.
    rst_n = 1'b1;
    tick(); tick();
    stall = 6'h01; br_e = 1'b1; br_addr = 64'h8000_0500;
    tick();
    br_e = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; stall = 6'h00;
    tick(); tick(); chk("reset_drops_pend", pc, 64'h8000_0004);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rst_n   = ($urandom_range(0, 99) >= 2);
      flush   = ($urandom_range(0, 99) < 6);
      new_pc  = rnd_addr();
      br_e    = ($urandom_range(0, 99) < 20);
      br_addr = rnd_addr();
      stall   = 6'($urandom_range(0, 63) & 62) | 6'($urandom_range(0, 99) < 30);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
